ov7670_config_sequencer: RTL

Reads the OV7670 register-configuration ROM entry by entry and turns each entry into one SCCB register write. Each write is issued to the SCCB master over a start/done handshake. The block interprets the ROM's two markers: 0xFFF0 is a timed delay and 0xFFFF is end-of-table. It sits between the config ROM and the SCCB master, and raises config_done once the camera is configured.

---
 rtl/ov7670_pkg.sv | 29 ++
 rtl/ov7670_config_sequencer_if.sv | 31 +++
 rtl/cfg_down_counter.sv | 28 ++
 rtl/ov7670_config_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 configuration path: ROM markers, ROM address width,
// the sequencer state type and a counter-width helper.
package ov7670_pkg;

  localparam int unsigned ROM_ADDR_W = 8;

  // Full 16-bit words that are never issued as register writes.
  localparam logic [15:0] ROM_END_MARKER   = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY_MARKER = 16'hFFF0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitRom,
    StDecode,
    StIssue,
    StWaitDone,
    StDelay,
    StDone
  } cfg_state_t;

  // Counter width able to hold max_val, never narrower than 32 bits.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w > 32) ? w : 32;
  endfunction

endpackage

// File: rtl/ov7670_config_sequencer_if.sv
// Request/response handshake between the config sequencer and the SCCB master.
interface ov7670_config_sequencer_if;

  logic       sccb_start;
  logic [7:0] sccb_reg_addr;
  logic [7:0] sccb_reg_data;
  logic       sccb_busy;
  logic       sccb_done;
  logic       sccb_nack;

  // Sequencer side: issues writes.
  modport master (
    output sccb_start,
    output sccb_reg_addr,
    output sccb_reg_data,
    input  sccb_busy,
    input  sccb_done,
    input  sccb_nack
  );

  // SCCB master side: executes writes.
  modport slave (
    input  sccb_start,
    input  sccb_reg_addr,
    input  sccb_reg_data,
    output sccb_busy,
    output sccb_done,
    output sccb_nack
  );

endinterface

// File: rtl/cfg_down_counter.sv
// Loadable down-counter that stops at zero and flags it.
module cfg_down_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Load wins over counting; counting holds at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM and turns each entry into one SCCB register write,
// honouring the delay and end-of-table markers, with retry on NACK or timeout.
module ov7670_config_sequencer
  import ov7670_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES   = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  output logic [ROM_ADDR_W-1:0]     o_rom_addr,
  input  logic [15:0]               i_rom_data,
  ov7670_config_sequencer_if.master sccb,
  output logic                      o_config_busy,
  output logic                      o_config_done,
  output logic [7:0]                o_err_count
);

  localparam int unsigned DlyW   = cnt_width(DELAY_CYCLES);
  localparam int unsigned ToW    = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

  // Counters run from N-1 down to 0 so the state lasts exactly N cycles.
  localparam logic [DlyW-1:0] DlyLoad = DlyW'((DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0);
  localparam logic [ToW-1:0]  ToLoad  = ToW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  cfg_state_t            r_state;
  logic [ROM_ADDR_W-1:0] r_rom_addr;
  logic                  r_sccb_start;
  logic [7:0]            r_reg_addr;
  logic [7:0]            r_reg_data;
  logic                  r_config_busy;
  logic                  r_config_done;
  logic [7:0]            r_err_count;
  logic [RetryW-1:0]     r_retry;

  logic w_is_end;
  logic w_is_delay;
  logic w_dly_load;
  logic w_dly_en;
  logic w_dly_zero;
  logic w_to_load;
  logic w_to_en;
  logic w_to_zero;
  logic w_retry_left;
  logic w_fail;
  logic w_ok;
  logic w_advance;

  assign w_is_end   = (i_rom_data == ROM_END_MARKER);
  assign w_is_delay = (i_rom_data == ROM_DELAY_MARKER);

  assign w_dly_load = (r_state == StDecode) && w_is_delay;
  assign w_dly_en   = (r_state == StDelay);
  assign w_to_load  = (r_state == StIssue) && !sccb.sccb_busy;
  assign w_to_en    = (r_state == StWaitDone);

  assign w_retry_left = (32'(r_retry) < MAX_RETRY);

  // sccb_done outranks a timeout expiring on the same cycle.
  assign w_ok   = (r_state == StWaitDone) && sccb.sccb_done && !sccb.sccb_nack;
  assign w_fail = (r_state == StWaitDone) && (sccb.sccb_done ? sccb.sccb_nack : w_to_zero);

  // Move to the next ROM entry: success, exhausted retries, or delay elapsed.
  assign w_advance = w_ok || (w_fail && !w_retry_left) || ((r_state == StDelay) && w_dly_zero);

  cfg_down_counter #(
    .WIDTH (DlyW)
  ) u_delay_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_dly_load),
    .i_load_val (DlyLoad),
    .i_en       (w_dly_en),
    .o_zero     (w_dly_zero)
  );

  cfg_down_counter #(
    .WIDTH (ToW)
  ) u_timeout_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_to_load),
    .i_load_val (ToLoad),
    .i_en       (w_to_en),
    .o_zero     (w_to_zero)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_rom_addr    <= '0;
      r_sccb_start  <= 1'b0;
      r_reg_addr    <= '0;
      r_reg_data    <= '0;
      r_config_busy <= 1'b0;
      r_config_done <= 1'b0;
      r_err_count   <= '0;
      r_retry       <= '0;
    end else begin
      r_sccb_start <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_rom_addr    <= '0;
            r_err_count   <= '0;
            r_config_done <= 1'b0;
            r_config_busy <= 1'b1;
            r_retry       <= '0;
            r_state       <= StFetch;
          end
        end
        StFetch:   r_state <= StWaitRom;
        StWaitRom: r_state <= StDecode;
        StDecode: begin
          if (w_is_end) begin
            r_config_busy <= 1'b0;
            r_config_done <= 1'b1;
            r_state       <= StDone;
          end else if (w_is_delay) begin
            r_state <= StDelay;
          end else begin
            r_reg_addr <= i_rom_data[15:8];
            r_reg_data <= i_rom_data[7:0];
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          if (!sccb.sccb_busy) begin
            r_sccb_start <= 1'b1;
            r_state      <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (w_fail) begin
            if (w_retry_left) begin
              r_retry <= r_retry + 1'b1;
              r_state <= StIssue;
            end else if (r_err_count != 8'hFF) begin
              r_err_count <= r_err_count + 8'd1;
            end
          end
        end
        StDelay: begin
          // Exit handled by the advance logic below.
        end
        default: r_state <= StIdle;
      endcase

      // The last ROM address ends the table rather than wrapping to 0.
      if (w_advance) begin
        r_retry <= '0;
        if (r_rom_addr == '1) begin
          r_config_busy <= 1'b0;
          r_config_done <= 1'b1;
          r_state       <= StDone;
        end else begin
          r_rom_addr <= r_rom_addr + 1'b1;
          r_state    <= StFetch;
        end
      end
    end
  end

  assign o_rom_addr         = r_rom_addr;
  assign sccb.sccb_start    = r_sccb_start;
  assign sccb.sccb_reg_addr = r_reg_addr;
  assign sccb.sccb_reg_data = r_reg_data;
  assign o_config_busy      = r_config_busy;
  assign o_config_done      = r_config_done;
  assign o_err_count        = r_err_count;

endmodule
